instr_fetch_cache: RTL
======================

Name: instr_fetch_cache

Overview:
- Instruction-fetch end of the program-counter interface: consumes the registered PC and returns the 32-bit instruction at that address.
- Small direct-mapped instruction cache between the PC register and a block-wide, multi-cycle instruction memory.
- On a miss it raises BUSYWAIT so the PC register and the pipeline hold, then fills a 128-bit line from memory.

Parameters:
- LINES, 8, number of cache lines; power of two, ≥2; INDEX_W = log2(LINES).
- TAG_W, 28-INDEX_W, tag width (derived; not overridden).

Ports:
- CLK  in  1  rising-edge clock.
- RESET  in  1  asynchronous, active-low reset (0 = reset asserted).
- PC  in  32  byte address of the instruction to fetch; word aligned, PC[1:0] ignored.
- INSTRUCTION  out  32  fetched instruction; valid when BUSYWAIT=0.
- BUSYWAIT  out  1  high = fetch not complete; PC register and pipeline must hold.
- MEM_READ  out  1  block-read request to instruction memory.
- MEM_ADDRESS  out  28  block address (byte address [31:4]).
- MEM_READDATA  in  128  block data; word w occupies bits [32w+31:32w].
- MEM_BUSYWAIT  in  1  memory busy; data valid on a posedge where MEM_READ=1 and MEM_BUSYWAIT=0.

Behaviour:
- Address split: offset = PC[3:2], index = PC[4+INDEX_W-1:4], tag = PC[31:4+INDEX_W].
- Storage per line: valid bit, tag, 128-bit data. Data and tags need no reset; valid bits are cleared by reset.
- While RESET=0:
  - All valid bits cleared; state = IDLE.
  - Outputs: MEM_READ=0, MEM_ADDRESS=0, BUSYWAIT=0, INSTRUCTION=32'h0.
- FSM states: IDLE, FILL.
- IDLE, hit (valid[index] and tag match):
  - Combinational, zero-cycle latency: INSTRUCTION = data[index] word at offset; BUSYWAIT=0.
- IDLE, miss:
  - Combinational: BUSYWAIT=1 and INSTRUCTION=0 in the same cycle.
  - At the next posedge: latch PC[31:4] into MEM_ADDRESS, set MEM_READ=1, go to FILL.
- FILL:
  - MEM_READ=1, MEM_ADDRESS stable, BUSYWAIT=1.
  - On the posedge where MEM_BUSYWAIT=0: write MEM_READDATA into the line selected by the latched address, set its tag and valid, drop MEM_READ, return to IDLE.
  - Next cycle the lookup re-evaluates against the current PC, normally as a hit.
- Miss penalty: 1 cycle + memory wait cycles + 1 cycle; e.g. 3 MEM_BUSYWAIT cycles gives 5 stalled cycles.
- Eviction: a miss to a valid line overwrites it unconditionally; no write-back because instructions are read-only.
- PC change during FILL (should not happen while BUSYWAIT=1): the fill still completes to the latched address, then the new PC is looked up in IDLE.
- MEM_READDATA is never sampled while MEM_READ=0; MEM_BUSYWAIT is ignored in IDLE.
- Reset asserted mid-FILL:
  - Immediately (asynchronously): MEM_READ=0, valids cleared, state IDLE.
  - The partial fill is discarded and no line is written.
- Reset deasserted: the first fetch (PC=0) is always a miss.

Optional Feature:
- Macro: INSTR_FETCH_CACHE_STATS_EN.
- Defined:
  - Adds outputs HIT_COUNT[15:0] and MISS_COUNT[15:0], both cleared by reset and saturating at 16'hFFFF.
  - HIT_COUNT increments on every posedge in IDLE with a hit.
  - MISS_COUNT increments on every IDLE→FILL transition.
- Undefined: neither port nor counter exists; behaviour otherwise identical.

Test Plan:
- Reset then release, PC=0, memory returns 128'h0000000C_00000008_00000004_00000000 after 3 MEM_BUSYWAIT cycles:
  - BUSYWAIT high 5 cycles; MEM_ADDRESS=28'h0000000 while MEM_READ=1.
  - Then INSTRUCTION=32'h00000000, BUSYWAIT=0.
- After that fill, PC=4, 8, 0xC → INSTRUCTION=4, 8, 0xC; zero stall cycles; MEM_READ stays 0.
- LINES=8, PC=0x80 (index 0, tag 1) after the line for PC=0 is filled:
  - Miss, MEM_ADDRESS=28'h0000008; new data installed.
  - PC=0 afterwards misses again.
- RESET driven low during FILL with MEM_BUSYWAIT=1:
  - MEM_READ=0 and BUSYWAIT=0 immediately.
  - After release, PC=0 misses again, proving valids were cleared.
- Memory with 0 wait cycles (MEM_BUSYWAIT=0 throughout) → exactly 2 stall cycles per miss.
- With INSTR_FETCH_CACHE_STATS_EN: sequence of 1 miss then 3 hit cycles → MISS_COUNT=1, HIT_COUNT=3.

Source files
------------

// File: rtl/instr_fetch_cache.sv
// instr_fetch_cache: direct-mapped instruction cache sitting between the PC
// register and a block-wide, multi-cycle instruction memory. A hit returns
// the instruction combinationally. A miss raises BUSYWAIT and fills one
// 128-bit line from memory.
//
// Optional build macro INSTR_FETCH_CACHE_STATS_EN adds the saturating
// HIT_COUNT / MISS_COUNT outputs.
//
// state | meaning
// IDLE  | lookup on the current PC; a miss starts a fill at the next edge
// FILL  | block read outstanding to the latched MEM_ADDRESS
module instr_fetch_cache #(
  parameter int LINES = 8
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [31:0]  PC,
  output logic [31:0]  INSTRUCTION,
  output logic         BUSYWAIT,
  output logic         MEM_READ,
  output logic [27:0]  MEM_ADDRESS,
  input  logic [127:0] MEM_READDATA,
  input  logic         MEM_BUSYWAIT
`ifdef INSTR_FETCH_CACHE_STATS_EN
  ,
  output logic [15:0]  HIT_COUNT,
  output logic [15:0]  MISS_COUNT
`endif
);

  localparam int INDEX_W = $clog2(LINES);
  localparam int TAG_W   = 28 - INDEX_W;

  typedef enum logic {IDLE, FILL} state_t;

  state_t state_q;
  state_t state_d;

  logic [1:0]         pc_offset;
  logic [INDEX_W-1:0] pc_index;
  logic [TAG_W-1:0]   pc_tag;
  logic [INDEX_W-1:0] fill_index;
  logic [TAG_W-1:0]   fill_tag;
  logic               pc_unused;

  logic [127:0]       data_q [LINES];
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [LINES-1:0]   valid_q;

  logic               hit;
  logic               start_fill;
  logic               fill_done;

  assign pc_offset  = PC[3:2];
  assign pc_index   = PC[4 +: INDEX_W];
  assign pc_tag     = PC[4+INDEX_W +: TAG_W];
  // Byte lanes within a word are irrelevant to a word-aligned fetch.
  assign pc_unused  = ^PC[1:0];

  // The line being filled is addressed by the latched block address, not
  // the live PC, so a PC change mid-fill cannot redirect the write.
  assign fill_index = MEM_ADDRESS[INDEX_W-1:0];
  assign fill_tag   = MEM_ADDRESS[27:INDEX_W];

  assign hit        = valid_q[pc_index] && (tag_q[pc_index] == pc_tag);
  assign start_fill = (state_q == IDLE) && !hit;
  assign fill_done  = (state_q == FILL) && !MEM_BUSYWAIT;

  // State register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: a miss opens a fill, memory ready closes it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!hit)          state_d = FILL;
      FILL:    if (!MEM_BUSYWAIT) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Outputs; RESET gates BUSYWAIT and INSTRUCTION so both read 0 while reset is held.
  always_comb begin
    MEM_READ    = (state_q == FILL);
    BUSYWAIT    = RESET && ((state_q == FILL) || !hit);
    INSTRUCTION = 32'h0;
    if (RESET && (state_q == IDLE) && hit)
      INSTRUCTION = data_q[pc_index][{pc_offset, 5'b0} +: 32];
  end

  // Latch the block address of the missing fetch when the fill starts.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)          MEM_ADDRESS <= 28'h0;
    else if (start_fill) MEM_ADDRESS <= PC[31:4];
  end

  // Valid bits: cleared by reset, set when a fill lands.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)         valid_q <= '0;
    else if (fill_done) valid_q[fill_index] <= 1'b1;
  end

  // Data and tag storage; this storage has no reset because the valid bit guards it.
  always_ff @(posedge CLK) begin
    if (fill_done) begin
      data_q[fill_index] <= MEM_READDATA;
      tag_q[fill_index]  <= fill_tag;
    end
  end

`ifdef INSTR_FETCH_CACHE_STATS_EN
  // Saturating hit/miss statistics.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      HIT_COUNT  <= 16'h0;
      MISS_COUNT <= 16'h0;
    end else begin
      if ((state_q == IDLE) && hit && (HIT_COUNT != 16'hFFFF))
        HIT_COUNT <= HIT_COUNT + 16'h1;
      if (start_fill && (MISS_COUNT != 16'hFFFF))
        MISS_COUNT <= MISS_COUNT + 16'h1;
    end
  end
`endif

endmodule
